// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants for the multiply/divide unit.
// The E-stage decoder and the hazard unit import the same op encodings and
// default latencies, so all three agree on what the 4-bit op field means.
package mdu_pkg;

  // Op field encodings; codes 9..15 are treated as MDU_NONE.
  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int unsigned MDU_MULT_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES  = 10;

  // True for the ops that launch a multi-cycle operation.
  function automatic logic is_start_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu.sv
// mdu: multiply/divide unit for the execute stage. Holds HI/LO, runs
// mult/multu/div/divu with a fixed latency set by a down-counter, and
// performs mthi/mtlo writes and mfhi/mflo reads.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   op    - 4-bit op code (mdu_pkg encodings)
//   A, B  - rs / rt operands from the E-stage forwarding mux
//   start - comb, op is a mult/div launch
//   busy  - registered, an operation is in flight
//   out   - comb, HI on MFHI, LO on MFLO, else 0
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] out
);

  mdu_state_e  state_q, state_d;
  logic [31:0] hi, lo, pend_hi, pend_lo;
  logic [3:0]  cnt;
  logic        no_commit;

  logic signed [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] divisor, quot_s, rem_s, quot_u, rem_u;
  logic [31:0] res_hi, res_lo;
  logic        div_zero, div_ovf;

  // Result datapath. The divisor is forced to 1 on divide-by-zero so the
  // behavioural operators never see a zero; that result is never committed.
  always_comb begin
    prod_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u   = {32'b0, A} * {32'b0, B};
    div_zero = (B == '0);
    divisor  = div_zero ? 32'd1 : B;
    div_ovf  = (A == 32'h8000_0000) && (B == '1);
    quot_s   = $signed(A) / $signed(divisor);
    rem_s    = $signed(A) % $signed(divisor);
    if (div_ovf) begin
      quot_s = A;
      rem_s  = '0;
    end
    quot_u = A / divisor;
    rem_u  = A % divisor;
    res_hi = '0;
    res_lo = '0;
    case (op)
      MDU_MULT:  {res_hi, res_lo} = prod_s;
      MDU_MULTU: {res_hi, res_lo} = prod_u;
      MDU_DIV:   begin res_hi = rem_s; res_lo = quot_s; end
      MDU_DIVU:  begin res_hi = rem_u; res_lo = quot_u; end
      default:   ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_BUSY;
      ST_BUSY: if (cnt == 4'd1) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    start = is_start_op(op);
    busy  = (state_q == ST_BUSY);
    case (op)
      MDU_MFHI: out = hi;
      MDU_MFLO: out = lo;
      default:  out = '0;
    endcase
  end

  // HI/LO and in-flight bookkeeping. While busy every incoming op is
  // dropped, including on the commit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi        <= '0;
      lo        <= '0;
      pend_hi   <= '0;
      pend_lo   <= '0;
      cnt       <= '0;
      no_commit <= 1'b0;
    end else if (state_q == ST_BUSY) begin
      if (cnt == 4'd1) begin
        if (!no_commit) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
        cnt       <= '0;
        no_commit <= 1'b0;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end else if (start) begin
      pend_hi   <= res_hi;
      pend_lo   <= res_lo;
      cnt       <= (op == MDU_MULT || op == MDU_MULTU) ? 4'(MULT_CYCLES)
                                                       : 4'(DIV_CYCLES);
      no_commit <= (op == MDU_DIV || op == MDU_DIVU) && div_zero;
    end else if (op == MDU_MTHI) begin
      hi <= A;
    end else if (op == MDU_MTLO) begin
      lo <= A;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: self-checking bench for mdu. A behavioural model tracks HI/LO and
// the remaining busy time with plain 64-bit arithmetic; directed cases cover
// the documented corner values, then random traffic exercises the rest.
module tb_mdu;
  import mdu_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  op;
  logic [31:0] A, B;
  logic        start, busy;
  logic [31:0] out;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model state
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  int          m_left = 0;
  bit          m_nc = 1'b0;
  logic [31:0] last_out;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .op(op), .A(A), .B(B),
    .start(start), .busy(busy), .out(out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_start(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ma, mb, q, r, p;
    m_nc = 1'b0;
    case (o)
      4'd1: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {m_phi, m_plo} = p;
      end
      4'd2: begin
        p = longint'({32'b0, a}) * longint'({32'b0, b});
        {m_phi, m_plo} = p;
      end
      4'd3: begin
        if (b == '0) m_nc = 1'b1;
        else begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          ma = (sa < 0) ? -sa : sa;
          mb = (sb < 0) ? -sb : sb;
          q = ma / mb;
          r = ma % mb;
          if ((sa < 0) != (sb < 0)) q = -q;
          if (sa < 0) r = -r;
          m_plo = q[31:0];
          m_phi = r[31:0];
        end
      end
      default: begin
        if (b == '0) m_nc = 1'b1;
        else begin
          ma = longint'({32'b0, a});
          mb = longint'({32'b0, b});
          q = ma / mb;
          r = ma % mb;
          m_plo = q[31:0];
          m_phi = r[31:0];
        end
      end
    endcase
  endtask

  task automatic model_edge(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic r);
    if (r) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_nc = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && !m_nc) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (o >= 4'd1 && o <= 4'd4) begin
      model_start(o, a, b);
      m_left = (o <= 4'd2) ? int'(MC) : int'(DC);
    end else if (o == 4'd5) begin
      m_hi = a;
    end else if (o == 4'd6) begin
      m_lo = a;
    end
  endtask

  task automatic do_cycle(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic r);
    logic [31:0] exp_out;
    op = o; A = a; B = b; rst = r;
    #1;
    exp_out = (o == 4'd7) ? m_hi : (o == 4'd8) ? m_lo : '0;
    check_eq("start", 32'(start), 32'(o >= 4'd1 && o <= 4'd4));
    check_eq("out", out, exp_out);
    last_out = out;
    @(posedge clk);
    model_edge(o, a, b, r);
    #1;
    check_eq("busy", 32'(busy), 32'(m_left != 0));
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) do_cycle(4'd0, '0, '0, 1'b0);
  endtask

  task automatic expect_hilo(input string tag, input logic [31:0] h, input logic [31:0] l);
    do_cycle(4'd7, '0, '0, 1'b0);
    check_eq({tag, "_hi"}, last_out, h);
    do_cycle(4'd8, '0, '0, 1'b0);
    check_eq({tag, "_lo"}, last_out, l);
  endtask

  // Launch an op and measure how many consecutive cycles busy stays high.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int unsigned exp_len);
    int unsigned len = 0;
    do_cycle(o, a, b, 1'b0);
    while (busy && len < 30) begin
      len++;
      do_cycle(4'd0, '0, '0, 1'b0);
    end
    check_eq({tag, "_busy_len"}, 32'(len), 32'(exp_len));
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    logic        rr;

    do_cycle(4'd0, '0, '0, 1'b1);
    do_cycle(4'd7, '0, '0, 1'b1);
    expect_hilo("reset", 32'h0, 32'h0);

    run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, MC);
    expect_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, MC);
    expect_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, DC);
    expect_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", 4'd4, 32'd7, 32'd2, DC);
    expect_hilo("divu", 32'd1, 32'd3);

    do_cycle(4'd5, 32'h11, '0, 1'b0);
    do_cycle(4'd6, 32'h22, '0, 1'b0);
    run_op("div0", 4'd3, 32'd5, 32'd0, DC);
    expect_hilo("div0", 32'h11, 32'h22);
    run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC);
    expect_hilo("divovf", 32'h0, 32'h8000_0000);

    // Writes and a second start while busy must be dropped.
    do_cycle(4'd1, 32'd7, 32'd6, 1'b0);
    do_cycle(4'd5, 32'hDEAD, '0, 1'b0);
    do_cycle(4'd1, 32'd2, 32'd2, 1'b0);
    idle(3);
    check_eq("reject_busy_low", 32'(busy), 32'd0);
    expect_hilo("reject", 32'h0, 32'd42);

    // Reset in the middle of a multiply discards it.
    do_cycle(4'd1, 32'd3, 32'd4, 1'b0);
    idle(1);
    do_cycle(4'd0, '0, '0, 1'b1);
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    idle(8);
    expect_hilo("rst_mid", 32'h0, 32'h0);

    do_cycle(4'd5, 32'hA, '0, 1'b0);
    do_cycle(4'd6, 32'hB, '0, 1'b0);
    expect_hilo("mf", 32'hA, 32'hB);
    do_cycle(4'd0, '0, '0, 1'b0);
    check_eq("none_out", last_out, 32'h0);
    do_cycle(4'd6, 32'h5, '0, 1'b0);
    do_cycle(4'd8, '0, '0, 1'b0);
    check_eq("mtlo_next", last_out, 32'h5);

    for (int i = 0; i < 800; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = 32'h8000_0000;
        1: rb = '0;
        2: rb = '1;
        3: begin ra = $urandom_range(0, 40); rb = $urandom_range(0, 9); end
        default: ;
      endcase
      rr = ($urandom_range(0, 99) == 0);
      do_cycle(ro, ra, rb, rr);
    end
    idle(DC + 1);
    expect_hilo("final", m_hi, m_lo);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
